control_unit: RTL and testbench
===============================

# control_unit

Hardwired control-step sequencer for the 32-bit datapath. It steps each instruction through fetch (T0–T2) and execute (T3–T6), driving the datapath's register-out, register-in, ALU-select and memory strobes. It decodes the IR opcode, stops on HALT, and counts retired instructions. It sits beside the datapath and drives the control strobes that the unit benches currently drive by hand.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- Clear  in  1  asynchronous reset, active-low (0 = reset).
- IR  in  32  instruction register contents; opcode = IR[31:27].
- mem_ready  in  1  memory read data valid.
- Stop  in  1  request halt at next instruction boundary.
- PCout, Zlowout, Zhiout, MDRout, HIout, LOout  out  1 each  bus source enables.
- PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin  out  1 each  register load enables.
- IncPC, Read  out  1 each  PC increment select; memory read.
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-file select/encode controls.
- alu_op  out  5  ALU operation select; equals the opcode during an ALU step, else 0.
- Run  out  1  1 while executing; 0 in HALT.
- illegal  out  1  sticky flag: an undefined opcode was executed.
- instr_count  out  16  retired-instruction count.

## Operation
- States: RST, T0, T1, T2, T3, T4, T5, T6, HALT.
- Outputs are decoded from the state register and the latched IR only. They never depend combinationally on mem_ready or Stop.
- RST: all strobes 0, Run=1.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin.
- T2: MDRout, IRin.
- R-type ALU opcodes 00011–01011:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op=opcode.
  - T5: Zlowout, Gra, Rin.
  - Next state: T0.
- MUL 01111 and DIV 10000:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, Zin, alu_op=opcode.
  - T5: Zlowout, LOin.
  - T6: Zhiout, HIin.
  - Next state: T0.
- MFHI 11000: T3: HIout, Gra, Rin. Next state: T0.
- MFLO 11001: T3: LOout, Gra, Rin. Next state: T0.
- NOP 11010: T3, no strobes. Next state: T0.
- HALT 11011: T3 goes to HALT.
- Any other opcode: executes as NOP and sets illegal=1. illegal clears only on reset.
- Retire: instr_count increments by 1 on the last execute step of every instruction, including NOP, illegal and HALT. It wraps from 0xFFFF to 0x0000.
- Stop:
  - Sampled at the cycle the sequencer would return to T0.
  - If Stop=1 there, the sequencer goes to HALT instead; the current instruction still retires.
  - Stop is ignored at every other step.
- HALT: all strobes 0, Run=0. Exit only via reset.
- At most one bus-source enable is 1 in any state.

## Timing
- Reset:
  - While Clear=0: state=RST, all strobes 0, alu_op=0, Run=1, illegal=0, instr_count=0.
  - Asserting Clear mid-instruction aborts it immediately and asynchronously; no partial retire.
- First rising edge after Clear rises: RST→T0.
- Every step is one cycle, except T1 when handshake is enabled (see Configuration).
- Latency per instruction, with no memory wait:

| Instruction | Cycles, T0 to retire |
|---|---|
| R-type | 6 |
| MUL/DIV | 7 |
| MFHI/MFLO/NOP | 4 |
| HALT | 4, then Run=0 from the next cycle |

- IR is sampled by decode from T3 onward. IR changing during T0–T2 has no effect.

## Configuration
- CU_MEM_HANDSHAKE_EN defined:
  - T1 holds its strobes until a cycle with mem_ready=1, then advances to T2 on that edge.
  - Each wait cycle adds 1 to latency.
  - Stop is not sampled during the wait.
- CU_MEM_HANDSHAKE_EN undefined:
  - T1 lasts exactly one cycle; mem_ready is ignored.
  - Memory data must be valid within that cycle.

## Test plan
- Clear low for 2 cycles, then high → RST for 1 cycle, then T0 shows PCout=MARin=IncPC=Zin=1. All other outputs 0 and instr_count=0 throughout reset.
- IR opcode 00101 (AND), R1/R2 selected, mem_ready tied 1:
  - T4 shows alu_op=5'b00101 with Grc, Rout and Zin.
  - T5 shows Gra, Rin and Zlowout.
  - instr_count 0→1 after 6 cycles; next cycle is T0.
- IR opcode 01111 (MUL) → T5 shows Zlowout+LOin, T6 shows Zhiout+HIin; retires in 7 cycles.
- With CU_MEM_HANDSHAKE_EN, mem_ready held 0 for 3 cycles in T1 → T1 strobes held for 4 cycles total; T2 follows the edge where mem_ready=1.
- IR opcode 11111 → illegal=1 after T3 and stays 1 across later valid instructions.
- Two cases reach HALT:
  - HALT opcode: Run=0 and instr_count=1.
  - Stop=1 during T5 of an ADD: HALT entered instead of T0 and the ADD retires.
- In both cases, Clear low then high restarts at RST→T0 with instr_count=0.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: hardwired control-step sequencer for the 32-bit datapath.
// Fetch is T0..T2. Execute is T3..T6, depending on the opcode in IR[31:27].
// Every strobe is a flop. It is computed from the next state and the next
// latched opcode, so no output depends combinationally on Stop or mem_ready.
// Optional build macro: CU_MEM_HANDSHAKE_EN. When it is defined, T1 waits
// for mem_ready. When it is undefined, T1 lasts one cycle.
module control_unit (
  input  logic        clk,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  input  logic        Stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhiout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [4:0]  alu_op,
  output logic        Run,
  output logic        illegal,
  output logic [15:0] instr_count
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4   = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_HALT = 4'd8
  } state_e;

  typedef struct packed {
    logic pc_out, zlow_out, zhi_out, mdr_out, hi_out, lo_out;
    logic pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in;
    logic inc_pc, read, gra, grb, grc, r_in, r_out;
    logic [4:0] alu_op;
    logic run;
  } ctl_t;

  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Reset strobe pattern: only Run, which is the LSB of ctl_t, is high.
  localparam ctl_t CTL_RST = ctl_t'(27'd1);

  function automatic logic is_rtype(input logic [4:0] op);
    return (op >= 5'b00011) && (op <= 5'b01011);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return is_rtype(op) || is_muldiv(op) || (op == OP_MFHI) || (op == OP_MFLO) ||
           (op == OP_NOP) || (op == OP_HALT);
  endfunction

  // Strobe decode for one control step.
  function automatic ctl_t decode(input state_e st, input logic [4:0] op);
    ctl_t c;
    c     = '0;
    c.run = 1'b1;
    case (st)
      S_RST: c.run = 1'b1;
      S_T0: begin
        c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1;
      end
      S_T1: begin
        c.zlow_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1;
      end
      S_T2: begin
        c.mdr_out = 1'b1; c.ir_in = 1'b1;
      end
      S_T3: begin
        if (is_rtype(op)) begin
          c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
        end else if (is_muldiv(op)) begin
          c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
        end else if (op == OP_MFHI) begin
          c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
        end else if (op == OP_MFLO) begin
          c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
        end else begin
          c.run = 1'b1;
        end
      end
      S_T4: begin
        c.r_out  = 1'b1; c.z_in = 1'b1; c.alu_op = op;
        if (is_muldiv(op)) c.grb = 1'b1;
        else               c.grc = 1'b1;
      end
      S_T5: begin
        c.zlow_out = 1'b1;
        if (is_muldiv(op)) begin
          c.lo_in = 1'b1;
        end else begin
          c.gra = 1'b1; c.r_in = 1'b1;
        end
      end
      S_T6: begin
        c.zhi_out = 1'b1; c.hi_in = 1'b1;
      end
      S_HALT:  c.run = 1'b0;
      default: c.run = 1'b0;
    endcase
    return c;
  endfunction

  state_e      state_q, state_d;
  logic [4:0]  opc_q, opc_d;
  ctl_t        ctl_q, ctl_d;
  logic        illegal_q, illegal_d;
  logic [15:0] count_q, count_d;
  logic        retire_s;
  logic        unused_s;

  // Only the opcode field of IR is decoded.
  assign unused_s = ^{IR[26:0], mem_ready};

  // Next-state, opcode latch, retire counting and illegal flag.
  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    retire_s  = 1'b0;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  state_d = S_T1;
      S_T1: begin
`ifdef CU_MEM_HANDSHAKE_EN
        if (mem_ready) state_d = S_T2;
        else           state_d = S_T1;
`else
        state_d = S_T2;
`endif
      end
      S_T2: begin
        // The opcode is captured on the edge into T3. Decode never reads IR again.
        state_d = S_T3;
        opc_d   = IR[31:27];
      end
      S_T3: begin
        if (is_rtype(opc_q) || is_muldiv(opc_q)) begin
          state_d = S_T4;
        end else begin
          retire_s = 1'b1;
          if (!is_legal(opc_q)) illegal_d = 1'b1;
          else                  illegal_d = illegal_q;
        end
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        if (is_muldiv(opc_q)) state_d = S_T6;
        else                  retire_s = 1'b1;
      end
      S_T6:    retire_s = 1'b1;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
    if (retire_s) begin
      count_d = count_q + 16'd1;
      if (Stop || (opc_q == OP_HALT)) state_d = S_HALT;
      else                            state_d = S_T0;
    end else begin
      count_d = count_q;
    end
  end

  // Strobes for the step being entered.
  always_comb begin
    ctl_d = decode(state_d, opc_d);
  end

  // State, opcode, strobe and counter registers. Clear acts asynchronously.
  always_ff @(posedge clk or negedge Clear) begin
    if (!Clear) begin
      state_q   <= S_RST;
      opc_q     <= 5'd0;
      ctl_q     <= CTL_RST;
      illegal_q <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      ctl_q     <= ctl_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign PCout       = ctl_q.pc_out;
  assign Zlowout     = ctl_q.zlow_out;
  assign Zhiout      = ctl_q.zhi_out;
  assign MDRout      = ctl_q.mdr_out;
  assign HIout       = ctl_q.hi_out;
  assign LOout       = ctl_q.lo_out;
  assign PCin        = ctl_q.pc_in;
  assign MARin       = ctl_q.mar_in;
  assign MDRin       = ctl_q.mdr_in;
  assign IRin        = ctl_q.ir_in;
  assign Yin         = ctl_q.y_in;
  assign Zin         = ctl_q.z_in;
  assign HIin        = ctl_q.hi_in;
  assign LOin        = ctl_q.lo_in;
  assign IncPC       = ctl_q.inc_pc;
  assign Read        = ctl_q.read;
  assign Gra         = ctl_q.gra;
  assign Grb         = ctl_q.grb;
  assign Grc         = ctl_q.grc;
  assign Rin         = ctl_q.r_in;
  assign Rout        = ctl_q.r_out;
  assign alu_op      = ctl_q.alu_op;
  assign Run         = ctl_q.run;
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit. Each instruction's expected step list is
// built from the instruction-class table. Every cycle is compared against it.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        Clear, mem_ready, Stop;
  logic [31:0] IR;
  logic PCout, Zlowout, Zhiout, MDRout, HIout, LOout;
  logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin;
  logic IncPC, Read, Gra, Grb, Grc, Rin, Rout, Run, illegal;
  logic [4:0]  alu_op;
  logic [15:0] instr_count;

  control_unit dut (
    .clk(clk), .Clear(Clear), .IR(IR), .mem_ready(mem_ready), .Stop(Stop),
    .PCout(PCout), .Zlowout(Zlowout), .Zhiout(Zhiout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
    .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .Run(Run), .illegal(illegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [26:0] bundle_s;
  assign bundle_s = {PCout, Zlowout, Zhiout, MDRout, HIout, LOout, PCin, MARin,
                     MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read, Gra, Grb,
                     Grc, Rin, Rout, alu_op, Run};

  localparam logic [26:0] M_PCOUT = 27'd1 << 26, M_ZLOW  = 27'd1 << 25;
  localparam logic [26:0] M_ZHI   = 27'd1 << 24, M_MDROUT = 27'd1 << 23;
  localparam logic [26:0] M_HIOUT = 27'd1 << 22, M_LOOUT = 27'd1 << 21;
  localparam logic [26:0] M_PCIN  = 27'd1 << 20, M_MARIN = 27'd1 << 19;
  localparam logic [26:0] M_MDRIN = 27'd1 << 18, M_IRIN  = 27'd1 << 17;
  localparam logic [26:0] M_YIN   = 27'd1 << 16, M_ZIN   = 27'd1 << 15;
  localparam logic [26:0] M_HIIN  = 27'd1 << 14, M_LOIN  = 27'd1 << 13;
  localparam logic [26:0] M_INCPC = 27'd1 << 12, M_READ  = 27'd1 << 11;
  localparam logic [26:0] M_GRA   = 27'd1 << 10, M_GRB   = 27'd1 << 9;
  localparam logic [26:0] M_GRC   = 27'd1 << 8,  M_RIN   = 27'd1 << 7;
  localparam logic [26:0] M_ROUT  = 27'd1 << 6,  M_RUN   = 27'd1;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_cnt;
  logic        m_ill;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [4:0] op);
    return (op >= 5'd3 && op <= 5'd11) || op == 5'd15 || op == 5'd16 ||
           (op >= 5'd24 && op <= 5'd27);
  endfunction

  // Compare one step, then advance one clock to the next negedge.
  task automatic step(input string tag, input logic [26:0] e, input logic stop_v);
    check(tag, 32'(bundle_s), 32'(e));
    check({tag, "_cnt"}, 32'(instr_count), 32'(m_cnt));
    check({tag, "_ill"}, 32'(illegal), 32'(m_ill));
    Stop = stop_v;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge. Clear is pulsed between edges. Returns at the negedge in T0.
  task automatic do_reset();
    #2 Clear = 1'b0;
    #1;
    m_cnt = 16'd0;
    m_ill = 1'b0;
    check("rst_async", 32'(bundle_s), 32'(M_RUN));
    check("rst_cnt", 32'(instr_count), 32'd0);
    check("rst_ill", 32'(illegal), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      Stop = 1'($urandom);
      check("rst_hold", 32'(bundle_s), 32'(M_RUN));
      check("rst_hold_cnt", 32'(instr_count), 32'd0);
    end
    Clear = 1'b1;
    Stop  = 1'b0;
    #1 check("rst_release", 32'(bundle_s), 32'(M_RUN));
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [4:0] op, input logic stop_end, input int nwait_in,
                           input int abort_at, output bit halted);
    logic [26:0] ex[$];
    logic [26:0] alu;
    logic [31:0] r;
    int k, nwait;
    halted = 1'b0;
    k      = 0;
    nwait  = nwait_in;
`ifndef CU_MEM_HANDSHAKE_EN
    nwait = 0;
`endif
    alu = 27'(op) << 1;
    if (op >= 5'd3 && op <= 5'd11) begin
      ex.push_back(M_GRB | M_ROUT | M_YIN);
      ex.push_back(M_GRC | M_ROUT | M_ZIN | alu);
      ex.push_back(M_ZLOW | M_GRA | M_RIN);
    end else if (op == 5'd15 || op == 5'd16) begin
      ex.push_back(M_GRA | M_ROUT | M_YIN);
      ex.push_back(M_GRB | M_ROUT | M_ZIN | alu);
      ex.push_back(M_ZLOW | M_LOIN);
      ex.push_back(M_ZHI | M_HIIN);
    end else if (op == 5'd24) begin
      ex.push_back(M_HIOUT | M_GRA | M_RIN);
    end else if (op == 5'd25) begin
      ex.push_back(M_LOOUT | M_GRA | M_RIN);
    end else begin
      ex.push_back(27'd0);
    end

    r = $urandom; IR = r; mem_ready = 1'($urandom);
    if (k == abort_at) begin do_reset(); return; end
    k++;
    step("T0", M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN, 1'($urandom));
    for (int w = 0; w < nwait; w++) begin
      r = $urandom; IR = r; mem_ready = 1'b0;
      if (k == abort_at) begin do_reset(); return; end
      k++;
      step("T1_wait", M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_RUN, 1'($urandom));
    end
    r = $urandom; IR = r;
`ifdef CU_MEM_HANDSHAKE_EN
    mem_ready = 1'b1;
`else
    mem_ready = 1'($urandom);
`endif
    if (k == abort_at) begin do_reset(); return; end
    k++;
    step("T1", M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_RUN, 1'($urandom));
    r = $urandom; r[31:27] = op; IR = r;
    if (k == abort_at) begin do_reset(); return; end
    k++;
    step("T2", M_MDROUT | M_IRIN | M_RUN, 1'($urandom));
    for (int i = 0; i < ex.size(); i++) begin
      if (k == abort_at) begin do_reset(); return; end
      k++;
      mem_ready = 1'($urandom);
      step($sformatf("T%0d_op%0d", i + 3, op), ex[i] | M_RUN,
           (i == ex.size() - 1) ? stop_end : 1'($urandom));
    end
    m_cnt = m_cnt + 16'd1;
    if (!legal(op)) m_ill = 1'b1;
    if (stop_end || op == 5'd27) begin
      halted = 1'b1;
      for (int i = 0; i < 3; i++) begin
        r = $urandom; IR = r; mem_ready = 1'($urandom);
        step("HALT", 27'd0, 1'($urandom));
      end
    end
  endtask

  initial begin
    bit h;
    logic [4:0] op;
    int ab;
    Clear = 1'b0; IR = 32'd0; Stop = 1'b0; mem_ready = 1'b0;
    m_cnt = 16'd0; m_ill = 1'b0;
    @(negedge clk);
    do_reset();
    run_instr(5'b00101, 1'b0, 0, -1, h);   // AND
    run_instr(5'b01111, 1'b0, 3, -1, h);   // MUL, three T1 wait cycles when enabled
    run_instr(5'b10000, 1'b0, 1, -1, h);   // DIV
    run_instr(5'b11000, 1'b0, 0, -1, h);   // MFHI
    run_instr(5'b11001, 1'b0, 0, -1, h);   // MFLO
    run_instr(5'b11010, 1'b0, 0, -1, h);   // NOP
    run_instr(5'b11111, 1'b0, 0, -1, h);   // undefined opcode
    run_instr(5'b00011, 1'b0, 0, -1, h);   // ADD, illegal stays set
    run_instr(5'b11011, 1'b0, 0, -1, h);   // HALT
    check("halt_flag", 32'(h), 32'd1);
    do_reset();
    run_instr(5'b00011, 1'b1, 0, -1, h);   // ADD with Stop on its last step
    check("stop_flag", 32'(h), 32'd1);
    do_reset();
    run_instr(5'b00101, 1'b0, 0, 5, h);    // Clear during T5: no retire
    run_instr(5'b01011, 1'b0, 0, -1, h);
    for (int n = 0; n < 80; n++) begin
      op = 5'($urandom_range(0, 31));
      ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_instr(op, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)), ab, h);
      if (h) do_reset();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
